// File: rtl/if_fetch_queue_pkg.sv
// Shared widths and sizing helpers for the variable-latency IF fetch queue.
package if_fetch_queue_pkg;

  localparam int unsigned PcWidth   = 32;
  localparam int unsigned InstWidth = 32;
  localparam int unsigned FqDepth   = 4;

  // Width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_ring_ptr.sv
// Wrap-around ring pointer with synchronous clear and increment.
module if_ring_ptr #(
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Power-of-two depth lets the natural binary overflow provide the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Variable-latency IF stage: in-order SRAM fetch requests, ring queue of {pc,inst},
// flush with cancellation of responses still in flight.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned PC_W   = PcWidth,
  parameter int unsigned INST_W = InstWidth,
  parameter int unsigned DEPTH  = FqDepth
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   pi_valid_i,
  input  logic [PC_W-1:0]        pi_pc_i,
  output logic                   if_allowin_o,
  output logic                   inst_req_o,
  output logic [PC_W-1:0]        inst_addr_o,
  input  logic                   inst_addr_ok_i,
  input  logic                   inst_data_ok_i,
  input  logic [INST_W-1:0]      inst_rdata_i,
  input  logic                   id_allowin_i,
  output logic                   if_to_id_valid_o,
  output logic [PC_W+INST_W-1:0] to_ifid_obus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];

  logic           req_fire, rsp_fill, pop_fire;
  logic [CNT_W:0] occupancy;

  assign occupancy    = {1'b0, cancel_q} + {1'b0, count_q};
  assign if_allowin_o = !flush_i && (count_q < CNT_W'(DEPTH))
                        && (occupancy < (CNT_W+1)'(DEPTH));
  assign inst_req_o   = pi_valid_i && if_allowin_o;
  assign inst_addr_o  = pi_pc_i;

  assign req_fire = inst_req_o && inst_addr_ok_i;
  assign rsp_fill = inst_data_ok_i && (cancel_q == '0) && !flush_i;

  assign if_to_id_valid_o = (count_q != '0) && done_q[head_ptr];
  assign to_ifid_obus     = if_to_id_valid_o ? {pc_q[head_ptr], inst_q[head_ptr]} : '0;
  assign pop_fire         = if_to_id_valid_o && id_allowin_i && !flush_i;

  // pend_q tracks allocated-but-not-filled entries; they become cancels on flush.
  always_comb begin
    count_d  = count_q;
    cancel_d = cancel_q;
    pend_d   = pend_q;
    done_d   = done_q;
    if (flush_i) begin
      count_d  = '0;
      pend_d   = '0;
      done_d   = '0;
      cancel_d = cancel_q + pend_q - CNT_W'(inst_data_ok_i);
    end else begin
      if (req_fire && !pop_fire) begin
        count_d = count_q + CNT_W'(1);
      end else if (!req_fire && pop_fire) begin
        count_d = count_q - CNT_W'(1);
      end
      if (req_fire && !rsp_fill) begin
        pend_d = pend_q + CNT_W'(1);
      end else if (!req_fire && rsp_fill) begin
        pend_d = pend_q - CNT_W'(1);
      end
      if (inst_data_ok_i && (cancel_q != '0)) begin
        cancel_d = cancel_q - CNT_W'(1);
      end
      if (req_fire) begin
        done_d[alloc_ptr] = 1'b0;
      end
      if (rsp_fill) begin
        done_d[fill_ptr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      cancel_q <= '0;
      pend_q   <= '0;
      done_q   <= '0;
    end else begin
      count_q  <= count_d;
      cancel_q <= cancel_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
    end
  end

  // Payload storage needs no reset: done_q and the output mask gate its use.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_q[alloc_ptr] <= pi_pc_i;
    end
    if (rsp_fill) begin
      inst_q[fill_ptr] <= inst_rdata_i;
    end
  end

  if_ring_ptr #(.PTR_W(PTR_W)) u_alloc_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .inc_i (req_fire),
    .ptr_o (alloc_ptr)
  );

  if_ring_ptr #(.PTR_W(PTR_W)) u_fill_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .inc_i (rsp_fill),
    .ptr_o (fill_ptr)
  );

  if_ring_ptr #(.PTR_W(PTR_W)) u_head_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .inc_i (pop_fire),
    .ptr_o (head_ptr)
  );

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    inst_data_ok_i |-> ((cancel_q != '0) || (pend_q != '0)));
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: vector table plus hand sequences, with an
// expected-pair scoreboard checked whenever ID takes an entry.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        pi_valid;
  logic [31:0] pi_pc;
  logic        if_allowin;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        id_allowin;
  logic        to_id_valid;
  logic [63:0] obus;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct packed {
    logic        fl;
    logic        pv;
    logic [31:0] pc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        push;
    logic [31:0] rpc;
    logic        ida;
    logic        ea;
    logic        er;
    logic        ev;
  } vec_t;

  vec_t tbl[$];

  if_fetch_queue #(.PC_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush),
    .pi_valid_i       (pi_valid),
    .pi_pc_i          (pi_pc),
    .if_allowin_o     (if_allowin),
    .inst_req_o       (inst_req),
    .inst_addr_o      (inst_addr),
    .inst_addr_ok_i   (addr_ok),
    .inst_data_ok_i   (data_ok),
    .inst_rdata_i     (rdata),
    .id_allowin_i     (id_allowin),
    .if_to_id_valid_o (to_id_valid),
    .to_ifid_obus     (obus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return ~pc ^ 32'h0000_0013;
  endfunction

  // Arguments: flush, pi_valid, pc, addr_ok, data_ok, rsp pc (or junk data), live, id_allowin,
  // expected allowin, req, valid. A live response carries inst_of(rpc) and is expected at ID.
  function automatic vec_t mv(input logic fl, input logic pv, input logic [31:0] pc,
                              input logic aok, input logic dok, input logic [31:0] rpc,
                              input logic push, input logic ida,
                              input logic ea, input logic er, input logic ev);
    vec_t v;
    v.fl = fl; v.pv = pv; v.pc = pc; v.aok = aok; v.dok = dok;
    v.rpc = rpc; v.push = push; v.ida = ida;
    v.rdata = push ? inst_of(rpc) : rpc;
    v.ea = ea; v.er = er; v.ev = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    flush      = v.fl;
    pi_valid   = v.pv;
    pi_pc      = v.pc;
    addr_ok    = v.aok;
    data_ok    = v.dok;
    rdata      = v.rdata;
    id_allowin = v.ida;
    if (v.dok && v.push) exp_q.push_back({v.rpc, inst_of(v.rpc)});
    #1;
    chk({nm, ".allowin"}, 64'(if_allowin), 64'(v.ea));
    chk({nm, ".req"}, 64'(inst_req), 64'(v.er));
    chk({nm, ".valid"}, 64'(to_id_valid), 64'(v.ev));
    if (v.er) chk({nm, ".addr"}, 64'(inst_addr), 64'(v.pc));
    if (!v.ev) chk({nm, ".obus_zero"}, obus, 64'd0);
    if (to_id_valid && v.ida && !v.fl) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s.unexpected_pair actual=%h required=none", nm, obus);
      end else begin
        chk({nm, ".pair"}, obus, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; pi_valid = 0; pi_pc = '0; addr_ok = 0;
    data_ok = 0; rdata = '0; id_allowin = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.allowin", 64'(if_allowin), 64'd1);
    chk("reset.req", 64'(inst_req), 64'd0);
    chk("reset.valid", 64'(to_id_valid), 64'd0);
    chk("reset.obus", obus, 64'd0);
    rst_n = 1'b1;
    #1;
    step(mv(0,0,32'h0,0,0,32'h0,0,1, 1,0,0), "idle");

    // Back-to-back fetch with one-cycle response latency, then fill to DEPTH with ID stalled.
    tbl.push_back(mv(0,1,32'h1c000000,1,0,32'h0,0,1,          1,1,0));
    tbl.push_back(mv(0,1,32'h1c000004,1,1,32'h1c000000,1,1,   1,1,0));
    tbl.push_back(mv(0,0,32'h0,0,1,32'h1c000004,1,1,          1,0,1));
    tbl.push_back(mv(0,0,32'h0,0,0,32'h0,0,1,                 1,0,1));
    tbl.push_back(mv(0,0,32'h0,0,0,32'h0,0,1,                 1,0,0));
    tbl.push_back(mv(0,1,32'h1c000010,1,0,32'h0,0,0,          1,1,0));
    tbl.push_back(mv(0,1,32'h1c000014,1,1,32'h1c000010,1,0,   1,1,0));
    tbl.push_back(mv(0,1,32'h1c000018,1,1,32'h1c000014,1,0,   1,1,1));
    tbl.push_back(mv(0,1,32'h1c00001c,1,1,32'h1c000018,1,0,   1,1,1));
    tbl.push_back(mv(0,1,32'h1c000020,1,1,32'h1c00001c,1,0,   0,0,1));
    tbl.push_back(mv(0,0,32'h0,0,0,32'h0,0,0,                 0,0,1));
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
    chk("full.count", 64'(dut.count_q), 64'd4);

    // Release ID: four in-order pops, allowin returns after the first.
    step(mv(0,0,32'h0,0,0,32'h0,0,1, 0,0,1), "rel0");
    step(mv(0,0,32'h0,0,0,32'h0,0,1, 1,0,1), "rel1");
    step(mv(0,0,32'h0,0,0,32'h0,0,1, 1,0,1), "rel2");
    step(mv(0,0,32'h0,0,0,32'h0,0,1, 1,0,1), "rel3");
    step(mv(0,0,32'h0,0,0,32'h0,0,1, 1,0,0), "rel4");

    // Flush with two outstanding; both late responses are dropped.
    step(mv(0,1,32'h1c000040,1,0,32'h0,0,1, 1,1,0), "fl2_a");
    step(mv(0,1,32'h1c000044,1,0,32'h0,0,1, 1,1,0), "fl2_b");
    step(mv(1,1,32'h1c000048,1,0,32'h0,0,1, 0,0,0), "fl2_flush");
    chk("fl2.cancel_after_flush", 64'(dut.cancel_q), 64'd2);
    step(mv(0,0,32'h0,0,1,32'hbad00001,0,1, 1,0,0), "fl2_drop0");
    step(mv(0,0,32'h0,0,1,32'hbad00002,0,1, 1,0,0), "fl2_drop1");
    chk("fl2.cancel_drained", 64'(dut.cancel_q), 64'd0);
    step(mv(0,1,32'h1c000100,1,0,32'h0,0,1,        1,1,0), "fl2_req");
    step(mv(0,0,32'h0,0,1,32'h1c000100,1,1,        1,0,0), "fl2_rsp");
    step(mv(0,0,32'h0,0,0,32'h0,0,1,               1,0,1), "fl2_pop");
    step(mv(0,0,32'h0,0,0,32'h0,0,1,               1,0,0), "fl2_idle");

    // Flush coincident with a response, three outstanding; cancel credit limits allowin.
    step(mv(0,1,32'h1c000200,1,0,32'h0,0,1, 1,1,0), "fl3_a");
    step(mv(0,1,32'h1c000204,1,0,32'h0,0,1, 1,1,0), "fl3_b");
    step(mv(0,1,32'h1c000208,1,0,32'h0,0,1, 1,1,0), "fl3_c");
    step(mv(1,0,32'h0,0,1,32'h1c000200,0,1, 0,0,0), "fl3_flush");
    chk("fl3.cancel_after_flush", 64'(dut.cancel_q), 64'd2);
    chk("fl3.count_after_flush", 64'(dut.count_q), 64'd0);
    step(mv(0,1,32'h1c000300,1,0,32'h0,0,1,        1,1,0), "fl3_r0");
    step(mv(0,1,32'h1c000304,1,0,32'h0,0,1,        1,1,0), "fl3_r1");
    step(mv(0,1,32'h1c000308,1,0,32'h0,0,1,        0,0,0), "fl3_credit_full");
    step(mv(0,1,32'h1c000308,1,1,32'hbad00003,0,1, 0,0,0), "fl3_drop0");
    step(mv(0,1,32'h1c000308,1,1,32'hbad00004,0,1, 1,1,0), "fl3_drop1");
    chk("fl3.cancel_drained", 64'(dut.cancel_q), 64'd0);
    step(mv(0,0,32'h0,0,1,32'h1c000300,1,1,        1,0,0), "fl3_rsp0");
    step(mv(0,0,32'h0,0,1,32'h1c000304,1,1,        1,0,1), "fl3_rsp1");
    step(mv(0,0,32'h0,0,1,32'h1c000308,1,1,        1,0,1), "fl3_rsp2");
    step(mv(0,0,32'h0,0,0,32'h0,0,1,               1,0,1), "fl3_pop");
    step(mv(0,0,32'h0,0,0,32'h0,0,1,               1,0,0), "fl3_idle");

    // SRAM refuses the request for five cycles.
    for (int i = 0; i < 5; i++)
      step(mv(0,1,32'h1c000400,0,0,32'h0,0,1, 1,1,0), $sformatf("stall%0d", i));
    chk("stall.count", 64'(dut.count_q), 64'd0);
    step(mv(0,1,32'h1c000400,1,0,32'h0,0,1, 1,1,0), "stall_accept");
    step(mv(0,0,32'h0,0,1,32'h1c000400,1,1, 1,0,0), "stall_rsp");
    step(mv(0,0,32'h0,0,0,32'h0,0,1,        1,0,1), "stall_pop");
    step(mv(0,0,32'h0,0,0,32'h0,0,1,        1,0,0), "stall_idle");

    chk("scoreboard.leftover", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
